sub_n_parts: RTL and testbench
==============================

SUB_N_PARTS -- requirements
Module: sub_n_parts

Interface
REQ-001 Parameter SIZE, default 256, operand bit width; SHALL be divisible by PARTS.
REQ-002 Parameter PARTS, default 4, number of equal chunks processed, one per cycle; SHALL be 2..16.
REQ-003 Parameter MODULUS, default 2^255-19 (SIZE bits), correction modulus, used only when SUB_MOD_CORRECT_EN is defined.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 start  input  1  request; sampled only in IDLE.
REQ-007 a  input  SIZE  minuend.
REQ-008 b  input  SIZE  subtrahend.
REQ-009 result  output  SIZE  difference, registered.
REQ-010 borrow  output  1  final borrow of a-b; 1 means a<b.
REQ-011 done  output  1  high when idle and result valid; low while busy.

Function
REQ-012 SHALL use FSM states IDLE, SUB, FIX (FIX only when SUB_MOD_CORRECT_EN is defined).
REQ-013 IDLE with start=1: SHALL latch a and b internally, clear the borrow chain and chunk counter, drop done, and enter SUB.
REQ-014 IDLE with start=0: SHALL hold result, borrow and done unchanged.
REQ-015 SUB: each cycle SHALL compute chunk k (bits k*SIZE/PARTS upward) as a_k - b_k - borrow_in, write it into result, and carry the borrow to chunk k+1, k counting 0..PARTS-1.
REQ-016 After chunk PARTS-1, without the macro, SHALL drive borrow with the final borrow, raise done, and return to IDLE.
REQ-017 Latency without the macro SHALL be PARTS+1 rising edges from the start-sampling edge to done=1, i.e. 5 for defaults.
REQ-018 result SHALL be (a-b) mod 2^SIZE, two's-complement wrap-around, with borrow=1 exactly when a<b.
REQ-019 start while done=0 SHALL be ignored, never queued.
REQ-020 Changes to a and b after the start-sampling edge SHALL NOT affect the operation in flight.
REQ-021 Back-to-back: start high in the same cycle done rises SHALL be accepted on the next edge (IDLE sampling).

Reset
REQ-022 rst=1 SHALL force IDLE, done=1, result=0, borrow=0, and clear latched operands and the counter, asynchronously, including mid-operation.
REQ-023 Deassertion SHALL leave the block idle; no operation SHALL resume.

Configuration
REQ-024 Macro SUB_MOD_CORRECT_EN defined: after SUB, SHALL enter FIX for PARTS cycles, adding (MODULUS AND-masked by the final borrow) to result chunk-wise with a carry chain; the final carry is discarded.
REQ-025 With the macro, latency SHALL be 2*PARTS+1 edges regardless of data (constant-time), and result SHALL equal (a-b) mod MODULUS for a,b < MODULUS.
REQ-026 With the macro, the borrow output SHALL still report the pre-correction borrow.
REQ-027 Macro undefined: no FIX state, no MODULUS logic, REQ-016/017 latency.

Structure
REQ-028 Package arith_pkg SHALL hold the FSM state typedef (shared with the staged adder) and a localparam chunk-width helper.
REQ-029 One sub-module chunk_addsub SHALL perform chunk add/subtract with carry/borrow in and out, selected by a mode bit, reused by SUB and FIX.

Verification (SIZE=256, PARTS=4)
REQ-030 a=5, b=3, start pulse -> done low, then high 5 edges later; result=2, borrow=0.
REQ-031 a=2^64, b=1 -> result=2^64-1, borrow propagated across the chunk 0/1 boundary, borrow=0.
REQ-032 a=0, b=1 -> macro off: result=2^256-1, borrow=1; macro on: result=2^255-20, borrow=1, done after 9 edges.
REQ-033 Macro on, a=b=2^255-20 -> result=0, borrow=0, latency 9 edges (same as the borrow case).
REQ-034 start held high during busy, with a, b changed mid-operation -> single result for the first operands; next operation starts only after done.
REQ-035 rst pulsed 2 cycles after start -> immediately done=1, result=0, borrow=0; the next start completes normally.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared FSM state type and chunk-width helper for the chunked subtractor.
// SUB_MOD_CORRECT_EN adds the FIX state used by the modular correction pass.
package arith_pkg;

`ifdef SUB_MOD_CORRECT_EN
   typedef enum logic [1:0] {IDLE, SUB, FIX} state_t;
`else
   typedef enum logic [0:0] {IDLE, SUB} state_t;
`endif

   function automatic int unsigned chunk_w(input int unsigned size, input int unsigned parts);
      return size / parts;
   endfunction

   localparam int unsigned DEFAULT_CHUNK_W = chunk_w(256, 4);

endpackage

// File: rtl/chunk_addsub.sv
// One chunk of a multi-cycle adder/subtractor with carry/borrow in and out.
// add_i=0: z = x - y - cin, cout = borrow; add_i=1: z = x + y + cin, cout = carry.
module chunk_addsub #(
   parameter int unsigned W = 64
) (
   input  logic         add_i,
   input  logic [W-1:0] x_i,
   input  logic [W-1:0] y_i,
   input  logic         cin_i,
   output logic [W-1:0] z_o,
   output logic         cout_o
);

   logic [W:0] acc;

   always_comb begin
      if (add_i) begin
         acc = {1'b0, x_i} + {1'b0, y_i} + (W+1)'(cin_i);
      end else begin
         // Negative differences land in [-2^W, -1], so bit W is the borrow.
         acc = {1'b0, x_i} - {1'b0, y_i} - (W+1)'(cin_i);
      end
   end

   assign z_o    = acc[W-1:0];
   assign cout_o = acc[W];

endmodule

// File: rtl/sub_n_parts.sv
// Multi-cycle SIZE-bit subtractor processing PARTS chunks, one per clock.
// Define SUB_MOD_CORRECT_EN for a constant-time add-back of MODULUS on borrow.
module sub_n_parts
   import arith_pkg::*;
#(
   parameter int unsigned   SIZE    = 256,
   parameter int unsigned   PARTS   = 4,
   parameter logic [SIZE-1:0] MODULUS = (SIZE'(1) << (SIZE-1)) - SIZE'(19)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   output logic [SIZE-1:0] result,
   output logic            borrow,
   output logic            done
);

   localparam int unsigned     CW   = chunk_w(SIZE, PARTS);
   localparam int unsigned     CNTW = (PARTS > 1) ? $clog2(PARTS) : 1;
   localparam logic [CNTW-1:0] LAST = CNTW'(PARTS - 1);

   state_t          state_q, state_d;
   logic [SIZE-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            chain_q, chain_d;
   logic            borrow_q, borrow_d;

   logic [31:0]     base;
   logic            last;
   logic            add_mode;
   logic [CW-1:0]   op_x, op_y, op_z;
   logic            op_cout;

   assign base = 32'(cnt_q) * CW;
   assign last = (cnt_q == LAST);

   always_comb begin
      add_mode = 1'b0;
      op_x     = a_q[base +: CW];
      op_y     = b_q[base +: CW];
`ifdef SUB_MOD_CORRECT_EN
      // FIX adds MODULUS only when SUB borrowed; the pass always runs so timing is data-independent.
      if (state_q == FIX) begin
         add_mode = 1'b1;
         op_x     = res_q[base +: CW];
         op_y     = MODULUS[base +: CW] & {CW{borrow_q}};
      end
`endif
   end

`ifndef SUB_MOD_CORRECT_EN
   logic unused_modulus;
   assign unused_modulus = ^MODULUS;
`endif

   chunk_addsub #(.W(CW)) u_chunk (
      .add_i  (add_mode),
      .x_i    (op_x),
      .y_i    (op_y),
      .cin_i  (chain_q),
      .z_o    (op_z),
      .cout_o (op_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start) state_d = SUB;
`ifdef SUB_MOD_CORRECT_EN
         SUB:  if (last) state_d = FIX;
         FIX:  if (last) state_d = IDLE;
`else
         SUB:  if (last) state_d = IDLE;
`endif
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      done     = (state_q == IDLE);
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      cnt_d    = cnt_q;
      chain_d  = chain_q;
      borrow_d = borrow_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               cnt_d   = '0;
               chain_d = 1'b0;
            end
         end
         SUB: begin
            res_d[base +: CW] = op_z;
            chain_d           = op_cout;
            cnt_d             = cnt_q + 1'b1;
            if (last) begin
               borrow_d = op_cout;
               chain_d  = 1'b0;
               cnt_d    = '0;
            end
         end
`ifdef SUB_MOD_CORRECT_EN
         FIX: begin
            res_d[base +: CW] = op_z;
            chain_d           = op_cout;
            cnt_d             = cnt_q + 1'b1;
            if (last) begin
               chain_d = 1'b0;
               cnt_d   = '0;
            end
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         cnt_q    <= '0;
         chain_q  <= 1'b0;
         borrow_q <= 1'b0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         cnt_q    <= cnt_d;
         chain_q  <= chain_d;
         borrow_q <= borrow_d;
      end
   end

   assign result = res_q;
   assign borrow = borrow_q;

endmodule

// File: tb/tb_sub_n_parts.sv
// Self-checking bench for sub_n_parts (SIZE=256, PARTS=4) against a plain arithmetic model.
// Honours SUB_MOD_CORRECT_EN for expected results and latency.
module tb_sub_n_parts;

   localparam int unsigned SIZE  = 256;
   localparam int unsigned PARTS = 4;
`ifdef SUB_MOD_CORRECT_EN
   localparam int unsigned LAT = 2*PARTS + 1;
`else
   localparam int unsigned LAT = PARTS + 1;
`endif
   localparam logic [SIZE-1:0] MODV = (256'd1 << 255) - 256'd19;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [SIZE-1:0] a, b;
   logic [SIZE-1:0] result;
   logic            borrow;
   logic            done;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic [SIZE-1:0] nxt_a, nxt_b;

   always #5 clk = ~clk;

   sub_n_parts #(.SIZE(SIZE), .PARTS(PARTS)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .result (result),
      .borrow (borrow),
      .done   (done)
   );

   task automatic check(input string tag, input logic [SIZE-1:0] obs, input logic [SIZE-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [SIZE-1:0] rnd();
      logic [SIZE-1:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
`ifdef SUB_MOD_CORRECT_EN
      r[SIZE-1] = 1'b0;
      if (r >= MODV) r = r - MODV;
`endif
      return r;
   endfunction

   function automatic logic [SIZE-1:0] ref_res(input logic [SIZE-1:0] x, input logic [SIZE-1:0] y);
      logic [SIZE-1:0] d;
      d = x - y;
`ifdef SUB_MOD_CORRECT_EN
      if (x < y) d = d + MODV;
`endif
      return d;
   endfunction

   // Called right after the start-sampling edge (+1); counts edges including that one.
   task automatic wait_done(input string tag, input logic [SIZE-1:0] x, input logic [SIZE-1:0] y);
      int unsigned n = 1;
      while (done !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check({tag, ":latency"}, SIZE'(n), SIZE'(LAT));
      check({tag, ":result"}, result, ref_res(x, y));
      check({tag, ":borrow"}, SIZE'(borrow), SIZE'(x < y));
   endtask

   task automatic run_op(input string tag, input logic [SIZE-1:0] x, input logic [SIZE-1:0] y,
                         input bit keep_start);
      @(negedge clk);
      a = x; b = y; start = 1'b1;
      @(posedge clk); #1;
      check({tag, ":busy"}, SIZE'(done), '0);
      if (keep_start) begin
         nxt_a = rnd();
         nxt_b = rnd();
         a = nxt_a;
         b = nxt_b;
      end else begin
         start = 1'b0;
         a = rnd();
         b = rnd();
      end
      wait_done(tag, x, y);
   endtask

   initial begin
      logic [SIZE-1:0] x, y, held;
      rst = 1'b1; start = 1'b0; a = '0; b = '0;
      #7;
      check("reset:done", SIZE'(done), SIZE'(1));
      check("reset:result", result, '0);
      check("reset:borrow", SIZE'(borrow), '0);
      @(negedge clk); rst = 1'b0;

      run_op("small", 256'd5, 256'd3, 1'b0);
      run_op("chunk_boundary", 256'd1 << 64, 256'd1, 1'b0);
      run_op("zero_minus_one", 256'd0, 256'd1, 1'b0);
      run_op("equal_max", MODV - 256'd1, MODV - 256'd1, 1'b0);

      held = result;
      repeat (3) @(posedge clk);
      #1;
      check("idle_hold:done", SIZE'(done), SIZE'(1));
      check("idle_hold:result", result, held);
      check("idle_hold:borrow", SIZE'(borrow), '0);

      for (int i = 0; i < 12; i++) begin
         x = rnd(); y = rnd();
         if (i % 3 == 0 && x > y) begin held = x; x = y; y = held; end
         run_op("random", x, y, 1'b0);
      end

      // start held through the operation with operands changing; next op is back-to-back.
      x = rnd(); y = rnd();
      run_op("hold_first", x, y, 1'b1);
      @(posedge clk); #1;
      check("hold_second:busy", SIZE'(done), '0);
      start = 1'b0;
      wait_done("hold_second", nxt_a, nxt_b);

      @(negedge clk);
      a = rnd(); b = rnd(); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check("midop_reset:done", SIZE'(done), SIZE'(1));
      check("midop_reset:result", result, '0);
      check("midop_reset:borrow", SIZE'(borrow), '0);
      @(negedge clk); rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("after_reset:done", SIZE'(done), SIZE'(1));
      check("after_reset:result", result, '0);
      run_op("after_reset_op", 256'd1000, 256'd1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
